// File: rtl/fast_bconv_stream.sv
// Streaming fast RNS base converter: c_j = sum_i ((x_i*z_i mod q_i)*y_ij) mod b_j, ready/valid on both sides.
// Optional macro FASTBCONV_PASSTHRU_EN: outputs k < L forward the captured x_k and only k >= L are MAC-computed.
module fast_bconv_stream #(
   parameter int RES_W         = 32,
   parameter int IN_BASIS_LEN  = 3,
   parameter int OUT_BASIS_LEN = 9,
   parameter logic [RES_W-1:0] IN_BASIS [IN_BASIS_LEN] = '{32'd3, 32'd5, 32'd7},
   parameter logic [RES_W-1:0] OUT_BASIS [OUT_BASIS_LEN] =
      '{32'd3, 32'd5, 32'd7, 32'd11, 32'd13, 32'd17, 32'd19, 32'd23, 32'd29},
   parameter logic [RES_W-1:0] ZiLUT [IN_BASIS_LEN] = '{32'd2, 32'd1, 32'd1},
   parameter logic [RES_W-1:0] YMODB [OUT_BASIS_LEN][IN_BASIS_LEN] = '{
      '{32'd2,  32'd0,  32'd0},
      '{32'd0,  32'd1,  32'd0},
      '{32'd0,  32'd0,  32'd1},
      '{32'd2,  32'd10, 32'd4},
      '{32'd9,  32'd8,  32'd2},
      '{32'd1,  32'd4,  32'd15},
      '{32'd16, 32'd2,  32'd15},
      '{32'd12, 32'd21, 32'd15},
      '{32'd6,  32'd21, 32'd15}},
   parameter int NUM_MAC = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [RES_W-1:0] input_RNSint [IN_BASIS_LEN],
   output logic             out_valid,
   input  logic             out_ready,
   output logic [RES_W-1:0] output_RNSint [OUT_BASIS_LEN]
);

   localparam int L = IN_BASIS_LEN;
   localparam int M = OUT_BASIS_LEN;
`ifdef FASTBCONV_PASSTHRU_EN
   localparam int J0 = L;
`else
   localparam int J0 = 0;
`endif
   localparam int M_EFF = M - J0;
   localparam int G     = (M_EFF + NUM_MAC - 1) / NUM_MAC;
   localparam int IW    = (L > 1) ? $clog2(L) : 1;
   localparam int JW    = (M > 1) ? $clog2(M) : 1;
   localparam int GW    = (G > 1) ? $clog2(G) : 1;
   localparam int WW    = 2 * RES_W;

   typedef logic [RES_W-1:0] rns_residue_t;
   typedef logic [WW-1:0]    wide_rns_residue_t;
   typedef enum logic [1:0] {IDLE = 2'd0, SCALE = 2'd1, ACCUM = 2'd2, DONE = 2'd3} state_t;

   function automatic rns_residue_t mul_mod(input rns_residue_t a, input rns_residue_t b,
                                            input rns_residue_t m);
      wide_rns_residue_t p;
      p = wide_rns_residue_t'(a) * wide_rns_residue_t'(b);
      return rns_residue_t'(p % wide_rns_residue_t'(m));
   endfunction

   // Both operands are already reduced, so a single conditional subtract suffices.
   function automatic rns_residue_t add_mod(input rns_residue_t a, input rns_residue_t b,
                                            input rns_residue_t m);
      logic [RES_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      s = (s >= {1'b0, m}) ? (s - {1'b0, m}) : s;
      return s[RES_W-1:0];
   endfunction

`ifdef FASTBCONV_PASSTHRU_EN
   function automatic bit basis_prefix_ok();
      for (int k = 0; k < L; k++) begin
         if (OUT_BASIS[k] != IN_BASIS[k]) return 1'b0;
      end
      return 1'b1;
   endfunction
   localparam bit PREFIX_OK = basis_prefix_ok();
   if (!PREFIX_OK) begin : g_bad_basis
      $error("fast_bconv_stream: OUT_BASIS[0..L-1] must equal IN_BASIS for passthrough");
   end
`endif

   state_t          state_q, state_d;
   rns_residue_t    x_q   [L];
   rns_residue_t    x_d   [L];
   rns_residue_t    a_q   [L];
   rns_residue_t    a_d   [L];
   rns_residue_t    acc_q [M];
   rns_residue_t    acc_d [M];
   logic [IW-1:0]   i_q, i_d;
   logic [GW-1:0]   g_q, g_d;
   logic            out_valid_q;
   logic            accept_s;
   logic            lane_on_s;
   int              j_s;
   logic [JW-1:0]   jx_s;

   // Next-state, datapath and handshake decode
   always_comb begin
      state_d   = state_q;
      x_d       = x_q;
      a_d       = a_q;
      acc_d     = acc_q;
      i_d       = i_q;
      g_d       = g_q;
      j_s       = 0;
      jx_s      = '0;
      lane_on_s = 1'b0;
      in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
      accept_s  = in_ready && in_valid;
      case (state_q)
         IDLE: begin
            state_d = accept_s ? SCALE : IDLE;
         end
         SCALE: begin
            a_d[i_q] = mul_mod(x_q[i_q], ZiLUT[i_q], IN_BASIS[i_q]);
            if (i_q == IW'(L - 1)) begin
               i_d     = '0;
               state_d = ACCUM;
            end else begin
               i_d = i_q + 1'b1;
            end
         end
         ACCUM: begin
            // Lane l of group g owns output index J0 + g*NUM_MAC + l; lanes past M stay idle.
            for (int l = 0; l < NUM_MAC; l++) begin
               j_s       = J0 + int'(g_q) * NUM_MAC + l;
               lane_on_s = (j_s < M);
               jx_s      = lane_on_s ? JW'(j_s) : '0;
               if (lane_on_s) begin
                  acc_d[jx_s] = add_mod(acc_q[jx_s],
                                        mul_mod(a_q[i_q], YMODB[jx_s][i_q], OUT_BASIS[jx_s]),
                                        OUT_BASIS[jx_s]);
               end else begin
                  acc_d[jx_s] = acc_d[jx_s];
               end
            end
            if (i_q == IW'(L - 1)) begin
               i_d = '0;
               if (g_q == GW'(G - 1)) begin
                  g_d     = '0;
                  state_d = DONE;
               end else begin
                  g_d = g_q + 1'b1;
               end
            end else begin
               i_d = i_q + 1'b1;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = in_valid ? SCALE : IDLE;
            end else begin
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      if (accept_s) begin
         x_d   = input_RNSint;
         acc_d = '{default: '0};
         i_d   = '0;
         g_d   = '0;
      end else begin
         x_d = x_d;
      end
   end

   // State, operand and accumulator registers with synchronous reset
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         x_q         <= '{default: '0};
         a_q         <= '{default: '0};
         acc_q       <= '{default: '0};
         i_q         <= '0;
         g_q         <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         a_q         <= a_d;
         acc_q       <= acc_d;
         i_q         <= i_d;
         g_q         <= g_d;
         out_valid_q <= (state_d == DONE);
      end
   end

   assign out_valid = out_valid_q;

   for (genvar k = 0; k < M; k++) begin : g_out
`ifdef FASTBCONV_PASSTHRU_EN
      if (k < L) begin : g_pass
         assign output_RNSint[k] = x_q[k];
      end else begin : g_mac
         assign output_RNSint[k] = acc_q[k];
      end
`else
      assign output_RNSint[k] = acc_q[k];
`endif
   end

endmodule
